adc_scan_sequencer: RTL and testbench
=====================================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of ADC channels scannable (1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: sample FIFO entries (power of 2, 4..64).
REQ-003 SHALL have port clk  in  1: system clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port trigger  in  1: single-cycle scan-start pulse from the one-second interval timer's timeout output.
REQ-006 SHALL have ports address in 3, chipselect in 1, read in 1, write_n in 1, writedata in 16: Avalon-MM slave.
REQ-007 SHALL have ports readdata out 16 (registered) and irq out 1.
REQ-008 SHALL have ports cmd_valid out 1, cmd_channel out 5, cmd_ready in 1: ADC command stream.
REQ-009 SHALL have ports rsp_valid in 1, rsp_channel in 5, rsp_data in 12: ADC response stream; no backpressure.

Function
REQ-010 SHALL map registers: 0 STATUS, 1 CONTROL, 2 CHMASK, 3 DATA, 4 THRESH; other addresses read 0; writes to them are ignored.
REQ-011 STATUS SHALL read {level[12:8], overrun[3], busy[2], overflow[1], nonempty[0]}; any write to STATUS clears overflow and overrun.
REQ-012 CONTROL bits SHALL be: [0] enable, [1] irq_en (stored, read back); [2] sw_trigger, [3] flush (write-only strobes, read 0).
REQ-013 CHMASK SHALL hold NUM_CH bits of channel enables; THRESH SHALL hold 5 bits; a THRESH value of 0 SHALL behave as 1.
REQ-014 readdata SHALL be updated one cycle after the access, as the registered mux of the addressed register.
REQ-015 A read of DATA with chipselect&&read SHALL return {rsp_channel[3:0], rsp_data[11:0]} of the FIFO head and pop it; a read on empty SHALL return 0 with no state change.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_RSP.
REQ-017 IDLE->ISSUE SHALL occur on (trigger or sw_trigger) when enable=1 and CHMASK!=0; ch_idx SHALL load the lowest set mask bit.
REQ-018 In ISSUE: cmd_valid=1 and cmd_channel=ch_idx; both SHALL be held stable until cmd_ready; handshake cycle -> WAIT_RSP.
REQ-019 In WAIT_RSP: on rsp_valid, push the sample; next higher set mask bit exists -> ISSUE with that index; otherwise -> IDLE.
REQ-020 rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-021 A trigger arriving while state!=IDLE SHALL be dropped and SHALL set overrun.
REQ-022 The trigger condition with enable=0 or CHMASK=0 SHALL be ignored silently.
REQ-023 Clearing enable mid-scan SHALL let the outstanding conversion complete and be pushed, then go to IDLE.
REQ-024 CHMASK writes mid-scan SHALL affect only the next-index search.
REQ-025 A push when full, without a same-cycle pop, SHALL drop the sample and set overflow; a simultaneous push and pop when full SHALL both succeed.
REQ-026 flush SHALL empty the FIFO in one cycle; flush takes priority over a same-cycle push or pop.
REQ-027 busy SHALL equal (state!=IDLE).
REQ-028 irq SHALL equal irq_en && (level>=THRESH || overflow); irq SHALL be combinational from registered state.

Reset
REQ-029 On reset_n low: state=IDLE; cmd_valid=0; cmd_channel=0; readdata=0; irq=0; FIFO empty; CONTROL=0; CHMASK=0; THRESH=1; overflow=0; overrun=0.
REQ-030 Reset assertion mid-scan SHALL abandon the scan immediately; a response arriving after release SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold register address constants, STATUS/CONTROL bit positions, the FSM state type and sample field widths.
REQ-032 The FIFO SHALL be the sub-module adc_sample_fifo: synchronous, single clock, with push, pop, flush, full, empty and level.

Verification
REQ-033 CHMASK=0x05, enable=1, trigger pulse, cmd_ready=1, rsp after 3 cycles -> commands on ch 0 then 2; level=2; DATA reads 0x0xxx then 0x2xxx.
REQ-034 cmd_ready held low 10 cycles -> cmd_valid and cmd_channel stable all 10 cycles; exactly one command accepted.
REQ-035 FIFO_DEPTH=16 full, one more sample -> overflow=1, level=16, irq=1 with irq_en=1; STATUS write -> overflow=0.
REQ-036 trigger during WAIT_RSP -> overrun=1; the scan completes unchanged; no second scan starts.
REQ-037 THRESH=3, irq_en=1, scan 3 channels -> irq rises the cycle after the 3rd push; one DATA read drops irq.
REQ-038 reset_n pulsed low in WAIT_RSP -> all REQ-029 values; a late rsp_valid leaves level=0.

Source files
------------

// File: rtl/adc_scan_sequencer_pkg.sv
// Shared definitions for the ADC scan sequencer.
// Contents: register address map, STATUS/CONTROL bit positions, sample field
// widths, the scan FSM state type, and a helper that finds the next enabled
// channel in a mask.
package adc_scan_sequencer_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_CHMASK  = 3'd2;
  localparam logic [2:0] ADDR_DATA    = 3'd3;
  localparam logic [2:0] ADDR_THRESH  = 3'd4;

  localparam int STAT_NONEMPTY_BIT = 0;
  localparam int STAT_OVERFLOW_BIT = 1;
  localparam int STAT_BUSY_BIT     = 2;
  localparam int STAT_OVERRUN_BIT  = 3;
  localparam int STAT_LEVEL_LSB    = 8;
  localparam int STAT_LEVEL_W      = 5;

  localparam int CTL_ENABLE_BIT  = 0;
  localparam int CTL_IRQ_EN_BIT  = 1;
  localparam int CTL_SW_TRIG_BIT = 2;
  localparam int CTL_FLUSH_BIT   = 3;

  localparam int CH_W       = 5;   // channel field on the command/response streams
  localparam int SMP_CH_W   = 4;   // channel bits kept in a stored sample
  localparam int SMP_DATA_W = 12;  // conversion result width
  localparam int SAMPLE_W   = SMP_CH_W + SMP_DATA_W;
  localparam int MASK_W     = 16;  // widest channel mask supported
  localparam int THRESH_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } scan_state_e;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CH_W:0] find_ch(input logic [MASK_W-1:0] mask,
                                            input logic [CH_W-1:0]   from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Bus bundle for the ADC scan sequencer.
// Groups the Avalon-MM slave (address/chipselect/read/write_n/writedata,
// readdata/irq) and the ADC command (cmd_*) and response (rsp_*) streams.
// slave  : view from the sequencer
// master : view from the host / ADC side
interface adc_scan_sequencer_if import adc_scan_sequencer_pkg::*; ();

  logic [2:0]            address;
  logic                  chipselect;
  logic                  read;
  logic                  write_n;
  logic [15:0]           writedata;
  logic [15:0]           readdata;
  logic                  irq;

  logic                  cmd_valid;
  logic [CH_W-1:0]       cmd_channel;
  logic                  cmd_ready;

  logic                  rsp_valid;
  logic [CH_W-1:0]       rsp_channel;
  logic [SMP_DATA_W-1:0] rsp_data;

  modport slave (
    input  address, chipselect, read, write_n, writedata,
    input  cmd_ready, rsp_valid, rsp_channel, rsp_data,
    output readdata, irq, cmd_valid, cmd_channel
  );

  modport master (
    output address, chipselect, read, write_n, writedata,
    output cmd_ready, rsp_valid, rsp_channel, rsp_data,
    input  readdata, irq, cmd_valid, cmd_channel
  );

endinterface

// File: rtl/adc_sample_fifo.sv
// Single-clock sample FIFO for the scan sequencer.
// Ports: clk, reset_n (async active-low), push_i/push_data_i, pop_i, flush_i,
// head_o (entry at the read pointer), full_o, empty_o, level_o, drop_o
// (pulses when a push is refused because the FIFO is full).
module adc_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO succeeds.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop && !flush_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer.
// On a scan trigger (timer pulse or software strobe) walks the enabled
// channels of CHMASK from lowest to highest, issuing one ADC command per
// channel and storing each response in a sample FIFO readable over Avalon-MM.
// Ports: clk, reset_n (async active-low), trigger (scan-start pulse),
// bus (slave modport: Avalon-MM registers, irq, ADC cmd/rsp streams).
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_IDLE     | no scan in progress, waiting for a trigger
// ST_ISSUE    | presenting cmd for ch_idx, held until cmd_ready
// ST_WAIT_RSP | command accepted, waiting for the conversion result
module adc_scan_sequencer import adc_scan_sequencer_pkg::*; #(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trigger,
  adc_scan_sequencer_if.slave   bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  scan_state_e           state_q, state_d;
  logic [CH_W-1:0]       ch_idx_q, ch_idx_d;
  logic                  enable_q, irq_en_q;
  logic [NUM_CH-1:0]     chmask_q;
  logic [THRESH_W-1:0]   thresh_q;
  logic                  overflow_q, overrun_q;
  logic [15:0]           readdata_q, readdata_d;

  logic                  wr_acc, rd_acc, wr_ctl, wr_status;
  logic                  sw_trig, flush, trig_any;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [SAMPLE_W-1:0]   fifo_head;
  logic [LVL_W-1:0]      fifo_level;
  logic [MASK_W-1:0]     mask_ext;
  logic [CH_W:0]         first_hit, next_hit;
  logic                  cmd_valid_c, overrun_evt;
  logic [THRESH_W-1:0]   thresh_eff;
  logic [STAT_LEVEL_W-1:0] level_sat;
  logic [15:0]           status_w;

  assign wr_acc    = bus.chipselect && !bus.write_n;
  assign rd_acc    = bus.chipselect && bus.read;
  assign wr_ctl    = wr_acc && (bus.address == ADDR_CONTROL);
  assign wr_status = wr_acc && (bus.address == ADDR_STATUS);
  assign sw_trig   = wr_ctl && bus.writedata[CTL_SW_TRIG_BIT];
  assign flush     = wr_ctl && bus.writedata[CTL_FLUSH_BIT];
  assign trig_any  = trigger || sw_trig;
  assign fifo_pop  = rd_acc && (bus.address == ADDR_DATA);

  assign mask_ext  = MASK_W'(chmask_q);
  assign first_hit = find_ch(mask_ext, '0);
  // The live mask is searched here, so a CHMASK write mid-scan only steers
  // which channel comes next.
  assign next_hit  = find_ch(mask_ext, ch_idx_q + 1'b1);

  adc_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i ({bus.rsp_channel[SMP_CH_W-1:0], bus.rsp_data}),
    .pop_i       (fifo_pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level),
    .drop_o      (fifo_drop)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ch_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    cmd_valid_c = 1'b0;
    fifo_push   = 1'b0;
    overrun_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_any && enable_q && first_hit[CH_W]) begin
          state_d  = ST_ISSUE;
          ch_idx_d = first_hit[CH_W-1:0];
        end
      end
      ST_ISSUE: begin
        cmd_valid_c = 1'b1;
        overrun_evt = trig_any;
        if (bus.cmd_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        overrun_evt = trig_any;
        if (bus.rsp_valid) begin
          fifo_push = 1'b1;
          // Dropping enable lets the in-flight conversion land, then stops.
          if (enable_q && next_hit[CH_W]) begin
            state_d  = ST_ISSUE;
            ch_idx_d = next_hit[CH_W-1:0];
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_sat = (32'(fifo_level) > 31) ? 5'd31 : STAT_LEVEL_W'(fifo_level);
    status_w  = '0;
    status_w[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level_sat;
    status_w[STAT_OVERRUN_BIT]  = overrun_q;
    status_w[STAT_BUSY_BIT]     = (state_q != ST_IDLE);
    status_w[STAT_OVERFLOW_BIT] = overflow_q;
    status_w[STAT_NONEMPTY_BIT] = !fifo_empty;

    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS:  readdata_d = status_w;
      ADDR_CONTROL: readdata_d = {14'b0, irq_en_q, enable_q};
      ADDR_CHMASK:  readdata_d = 16'(chmask_q);
      ADDR_DATA:    readdata_d = fifo_empty ? 16'h0000 : fifo_head;
      ADDR_THRESH:  readdata_d = 16'(thresh_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      chmask_q   <= '0;
      thresh_q   <= THRESH_W'(1);
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (wr_ctl) begin
        enable_q <= bus.writedata[CTL_ENABLE_BIT];
        irq_en_q <= bus.writedata[CTL_IRQ_EN_BIT];
      end
      if (wr_acc && (bus.address == ADDR_CHMASK)) chmask_q <= bus.writedata[NUM_CH-1:0];
      if (wr_acc && (bus.address == ADDR_THRESH)) thresh_q <= bus.writedata[THRESH_W-1:0];
      // A new event in the same cycle as the clearing write survives.
      overflow_q <= (overflow_q && !wr_status) || fifo_drop;
      overrun_q  <= (overrun_q && !wr_status) || overrun_evt;
      if (rd_acc) readdata_q <= readdata_d;
    end
  end

  assign thresh_eff      = (thresh_q == '0) ? THRESH_W'(1) : thresh_q;
  assign bus.irq         = irq_en_q && ((32'(fifo_level) >= 32'(thresh_eff)) || overflow_q);
  assign bus.readdata    = readdata_q;
  assign bus.cmd_valid   = cmd_valid_c;
  assign bus.cmd_channel = ch_idx_q;

  logic unused_bits;
  assign unused_bits = ^{bus.writedata, bus.rsp_channel[CH_W-1], fifo_full};

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;
  import adc_scan_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic trigger = 1'b0;

  adc_scan_sequencer_if bus();

  adc_scan_sequencer #(.NUM_CH(8), .FIFO_DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .trigger (trigger),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb[$];
  logic [4:0]  cmd_log[$];
  int rsp_cnt = 0;
  int rsp_delay = 3;
  bit expect_push = 1'b1;

  // ADC model: accepts each handshake, answers rsp_delay cycles later.
  logic [4:0]  r_ch;
  logic [11:0] r_data;
  initial begin
    bus.rsp_valid = 1'b0;
    bus.rsp_channel = '0;
    bus.rsp_data = '0;
    forever begin
      @(negedge clk); #1;
      while (bus.cmd_valid && bus.cmd_ready) begin
        r_ch = bus.cmd_channel;
        r_data = 12'($urandom_range(0, 4095));
        cmd_log.push_back(r_ch);
        repeat (rsp_delay - 1) @(negedge clk);
        #1;
        bus.rsp_valid = 1'b1;
        bus.rsp_channel = r_ch;
        bus.rsp_data = r_data;
        if (expect_push) sb.push_back({r_ch[3:0], r_data});
        @(negedge clk); #1;
        bus.rsp_valid = 1'b0;
        rsp_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic av_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic av_read(input logic [2:0] a, output logic [15:0] v);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.read = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    v = bus.readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    av_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic rd_data(input string tag);
    logic [15:0] v, e;
    e = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
    av_read(ADDR_DATA, v);
    check(tag, v, e);
  endtask

  task automatic pulse_trigger();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int i;
    i = 0;
    while (rsp_cnt < target && i < 400) begin
      @(negedge clk); #2;
      i++;
    end
    check("rsp_timeout", 16'(rsp_cnt >= target), 16'd1);
  endtask

  int base_c, base_r;

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.read = 1'b0;
    bus.write_n = 1'b1; bus.writedata = '0; bus.cmd_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.readdata, 16'h0000);
    check("rst_irq", 16'(bus.irq), 16'd0);
    check("rst_cmd_valid", 16'(bus.cmd_valid), 16'd0);
    check("rst_cmd_channel", 16'(bus.cmd_channel), 16'd0);
    reset_n = 1'b1;
    rd_chk("rst_status", ADDR_STATUS, 16'h0000);
    rd_chk("rst_control", ADDR_CONTROL, 16'h0000);
    rd_chk("rst_chmask", ADDR_CHMASK, 16'h0000);
    rd_chk("rst_thresh", ADDR_THRESH, 16'h0001);
    rd_chk("unmapped_rd", 3'd6, 16'h0000);

    // Basic two-channel scan (mask 0x05)
    av_write(ADDR_CHMASK, 16'h0005);
    av_write(ADDR_CONTROL, 16'h0001);
    rd_chk("chmask_rb", ADDR_CHMASK, 16'h0005);
    base_c = cmd_log.size(); base_r = rsp_cnt;
    pulse_trigger();
    wait_rsp(base_r + 2);
    check("a_cmd_count", 16'(cmd_log.size() - base_c), 16'd2);
    if (cmd_log.size() >= base_c + 2) begin
      check("a_cmd0_ch", 16'(cmd_log[base_c]), 16'd0);
      check("a_cmd1_ch", 16'(cmd_log[base_c + 1]), 16'd2);
    end
    rd_chk("a_status", ADDR_STATUS, 16'h0201);
    rd_data("a_data0");
    rd_data("a_data1");
    rd_data("a_data_empty");
    rd_chk("a_status_empty", ADDR_STATUS, 16'h0000);

    // Stalled command: cmd_ready low for 10 cycles
    bus.cmd_ready = 1'b0;
    av_write(ADDR_CHMASK, 16'h0002);
    base_c = cmd_log.size(); base_r = rsp_cnt;
    pulse_trigger();
    for (int i = 0; i < 10; i++) begin
      check("b_cmd_valid_held", 16'(bus.cmd_valid), 16'd1);
      check("b_cmd_channel_held", 16'(bus.cmd_channel), 16'd1);
      @(negedge clk);
    end
    rd_chk("b_status_busy", ADDR_STATUS, 16'h0004);
    check("b_no_accept", 16'(cmd_log.size() - base_c), 16'd0);
    bus.cmd_ready = 1'b1;
    wait_rsp(base_r + 1);
    check("b_one_accept", 16'(cmd_log.size() - base_c), 16'd1);
    rd_data("b_data");

    // Fill to 16 then overflow
    av_write(ADDR_THRESH, 16'd31);
    av_write(ADDR_CONTROL, 16'h0003);
    av_write(ADDR_CHMASK, 16'h00FF);
    base_r = rsp_cnt;
    pulse_trigger();
    wait_rsp(base_r + 8);
    pulse_trigger();
    wait_rsp(base_r + 16);
    check("c_irq_full_below_thr", 16'(bus.irq), 16'd0);
    rd_chk("c_status_full", ADDR_STATUS, 16'h1001);
    expect_push = 1'b0;
    av_write(ADDR_CHMASK, 16'h0001);
    pulse_trigger();
    wait_rsp(base_r + 17);
    check("c_irq_overflow", 16'(bus.irq), 16'd1);
    rd_chk("c_status_ovf", ADDR_STATUS, 16'h1003);
    av_write(ADDR_STATUS, 16'h0000);
    rd_chk("c_status_clr", ADDR_STATUS, 16'h1001);
    check("c_irq_clr", 16'(bus.irq), 16'd0);
    rd_data("c_data_oldest");
    rd_chk("c_status_15", ADDR_STATUS, 16'h0F01);
    av_write(ADDR_CONTROL, 16'h000B);
    sb.delete();
    expect_push = 1'b1;
    rd_chk("c_status_flushed", ADDR_STATUS, 16'h0000);
    rd_chk("c_control_rb", ADDR_CONTROL, 16'h0003);

    // Trigger during WAIT_RSP -> overrun, scan unchanged
    av_write(ADDR_CONTROL, 16'h0001);
    av_write(ADDR_CHMASK, 16'h0005);
    rsp_delay = 6;
    base_c = cmd_log.size(); base_r = rsp_cnt;
    pulse_trigger();
    pulse_trigger();
    wait_rsp(base_r + 2);
    repeat (10) @(negedge clk);
    check("d_cmd_count", 16'(cmd_log.size() - base_c), 16'd2);
    if (cmd_log.size() >= base_c + 2) begin
      check("d_cmd0_ch", 16'(cmd_log[base_c]), 16'd0);
      check("d_cmd1_ch", 16'(cmd_log[base_c + 1]), 16'd2);
    end
    rd_chk("d_status_overrun", ADDR_STATUS, 16'h0209);
    av_write(ADDR_STATUS, 16'h0000);
    rd_chk("d_status_clr", ADDR_STATUS, 16'h0201);
    rd_data("d_data0");
    rd_data("d_data1");
    rsp_delay = 3;

    // irq threshold 3
    av_write(ADDR_THRESH, 16'd3);
    av_write(ADDR_CONTROL, 16'h0003);
    av_write(ADDR_CHMASK, 16'h0007);
    base_r = rsp_cnt;
    pulse_trigger();
    for (int i = 0; i < 200 && rsp_cnt < base_r + 3; i++) begin
      @(negedge clk); #2;
      if (rsp_cnt < base_r + 3) check("e_irq_below_thr", 16'(bus.irq), 16'd0);
    end
    check("e_rsp3_seen", 16'(rsp_cnt >= base_r + 3), 16'd1);
    check("e_irq_at_thr", 16'(bus.irq), 16'd1);
    rd_data("e_data0");
    check("e_irq_after_pop", 16'(bus.irq), 16'd0);
    rd_data("e_data1");
    rd_data("e_data2");
    rd_chk("e_status_empty", ADDR_STATUS, 16'h0000);

    // Reset mid-scan, late response ignored
    av_write(ADDR_CONTROL, 16'h0001);
    av_write(ADDR_CHMASK, 16'h0002);
    rsp_delay = 6;
    expect_push = 1'b0;
    base_r = rsp_cnt;
    pulse_trigger();
    repeat (2) @(negedge clk);
    check("f_cmd_channel_pre", 16'(bus.cmd_channel), 16'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("f_rst_readdata", bus.readdata, 16'h0000);
    check("f_rst_cmd_valid", 16'(bus.cmd_valid), 16'd0);
    check("f_rst_cmd_channel", 16'(bus.cmd_channel), 16'd0);
    check("f_rst_irq", 16'(bus.irq), 16'd0);
    reset_n = 1'b1;
    wait_rsp(base_r + 1);
    repeat (2) @(negedge clk);
    rd_chk("f_status", ADDR_STATUS, 16'h0000);
    rd_chk("f_control", ADDR_CONTROL, 16'h0000);
    rd_chk("f_chmask", ADDR_CHMASK, 16'h0000);
    rd_chk("f_thresh", ADDR_THRESH, 16'h0001);
    expect_push = 1'b1;
    rsp_delay = 3;

    // Ignored triggers, then software trigger
    av_write(ADDR_CONTROL, 16'h0001);
    pulse_trigger();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("g_mask0_no_cmd", 16'(bus.cmd_valid), 16'd0);
    end
    rd_chk("g_status_mask0", ADDR_STATUS, 16'h0000);
    av_write(ADDR_CONTROL, 16'h0000);
    av_write(ADDR_CHMASK, 16'h0001);
    pulse_trigger();
    @(negedge clk);
    check("g_dis_no_cmd", 16'(bus.cmd_valid), 16'd0);
    rd_chk("g_status_dis", ADDR_STATUS, 16'h0000);
    av_write(ADDR_CONTROL, 16'h0001);
    base_r = rsp_cnt;
    av_write(ADDR_CONTROL, 16'h0005);
    wait_rsp(base_r + 1);
    rd_chk("g_control_strobe_rd0", ADDR_CONTROL, 16'h0001);
    rd_data("g_sw_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
